// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for pong (serve -> play -> point -> over).
// Ports:
//   clk, rst (async, active-high)
//   start, frame_tick, miss_l, miss_r  : single-cycle event inputs
//   ball_rst, ball_en, serve_dir        : ball gating / reseed control
//   score_l_inc, score_r_inc, score_clr : one-cycle pulses to score displays
//   score_l, score_r                    : 4-bit score copies
//   game_over, winner                   : match result (winner 0=left, 1=right)
// All outputs are registered; each is computed from the next state/scores.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 10,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_rst,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       score_l_inc,
  output logic       score_r_inc,
  output logic       score_clr,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
  logic                 serve_dir_q, serve_dir_d;
  logic                 winner_q, winner_d;
  logic                 game_over_q, game_over_d;
  logic                 ball_rst_q, ball_rst_d;
  logic                 ball_en_q, ball_en_d;
  logic                 score_l_inc_q, score_l_inc_d;
  logic                 score_r_inc_q, score_r_inc_d;
  logic                 score_clr_q, score_clr_d;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      serve_dir_q   <= 1'b0;
      winner_q      <= 1'b0;
      game_over_q   <= 1'b0;
      ball_rst_q    <= 1'b1;
      ball_en_q     <= 1'b0;
      score_l_inc_q <= 1'b0;
      score_r_inc_q <= 1'b0;
      score_clr_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
      ball_rst_q    <= ball_rst_d;
      ball_en_q     <= ball_en_d;
      score_l_inc_q <= score_l_inc_d;
      score_r_inc_q <= score_r_inc_d;
      score_clr_q   <= score_clr_d;
    end
  end

  // Next-state, score and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_dir_d   = serve_dir_q;
    winner_d      = winner_q;
    game_over_d   = game_over_q;
    score_l_inc_d = 1'b0;
    score_r_inc_d = 1'b0;
    score_clr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // miss_l wins a simultaneous miss; miss_r is dropped.
        if (miss_l) begin
          state_d       = ST_POINT;
          score_r_d     = score_r_q + SCORE_W'(1);
          score_r_inc_d = 1'b1;
          serve_dir_d   = 1'b0;
        end else if (miss_r) begin
          state_d       = ST_POINT;
          score_l_d     = score_l_q + SCORE_W'(1);
          score_l_inc_d = 1'b1;
          serve_dir_d   = 1'b1;
        end
      end
      ST_POINT: begin
        // serve_dir names the conceding side, so the scorer is its inverse.
        if (( serve_dir_q && score_l_q == SCORE_W'(WIN_SCORE)) ||
            (!serve_dir_q && score_r_q == SCORE_W'(WIN_SCORE))) begin
          state_d     = ST_OVER;
          winner_d    = ~serve_dir_q;
          game_over_d = 1'b1;
        end else begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          cnt_d       = '0;
          score_l_d   = '0;
          score_r_d   = '0;
          game_over_d = 1'b0;
          score_clr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ball_en_d  = (state_d == ST_PLAY);
    ball_rst_d = ~ball_en_d;
  end

  assign ball_rst    = ball_rst_q;
  assign ball_en     = ball_en_q;
  assign serve_dir   = serve_dir_q;
  assign score_l_inc = score_l_inc_q;
  assign score_r_inc = score_r_inc_q;
  assign score_clr   = score_clr_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed self-checking bench for pong_match_ctrl
// (SERVE_FRAMES=3, WIN_SCORE=10).
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, frame_tick, miss_l, miss_r;
  logic       ball_rst, ball_en, serve_dir;
  logic       score_l_inc, score_r_inc, score_clr;
  logic [3:0] score_l, score_r;
  logic       game_over, winner;

  int n_cmp = 0;
  int n_bad = 0;

  pong_match_ctrl #(.WIN_SCORE(10), .SERVE_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .miss_l(miss_l), .miss_r(miss_r), .ball_rst(ball_rst), .ball_en(ball_en),
    .serve_dir(serve_dir), .score_l_inc(score_l_inc), .score_r_inc(score_r_inc),
    .score_clr(score_clr), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Advance one clock; leaves time at posedge+1 for sampling and driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    miss_l = l; miss_r = r; cyc(); miss_l = 1'b0; miss_r = 1'b0;
  endtask

  // Three ticks spaced three cycles apart; releases the ball from SERVE.
  task automatic do_serve();
    for (int k = 0; k < 3; k++) begin
      cyc(); cyc();
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; frame_tick = 0; miss_l = 0; miss_r = 0;
    cyc(); cyc();
    n_cmp++; if ({ball_rst, ball_en, serve_dir} !== 3'b100) begin n_bad++; $display("FAIL reset_ball got=%b exp=100", {ball_rst, ball_en, serve_dir}); end
    n_cmp++; if ({score_l_inc, score_r_inc, score_clr, game_over, winner} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {score_l_inc, score_r_inc, score_clr, game_over, winner}); end
    n_cmp++; if ({score_l, score_r} !== 8'h00) begin n_bad++; $display("FAIL reset_scores got=%h exp=00", {score_l, score_r}); end
    rst = 1'b0; cyc();
    // Idle ignores ticks and misses.
    frame_tick = 1'b1; miss_r = 1'b1; cyc(); frame_tick = 1'b0; miss_r = 1'b0; cyc();
    n_cmp++; if ({ball_en, score_l} !== 5'b0) begin n_bad++; $display("FAIL idle_ignore got=%b exp=00000", {ball_en, score_l}); end
    // Build score_l=3, then reset asynchronously mid-PLAY.
    pulse_start();
    for (int i = 0; i < 3; i++) begin do_serve(); pulse_miss(1'b0, 1'b1); cyc(); end
    do_serve();
    n_cmp++; if ({ball_en, score_l} !== {1'b1, 4'd3}) begin n_bad++; $display("FAIL pre_reset_play got=%b/%0d exp=1/3", ball_en, score_l); end
    #2 rst = 1'b1; #1;
    n_cmp++; if ({ball_rst, ball_en, serve_dir, score_l, score_r, game_over} !== {3'b100, 8'h00, 1'b0}) begin n_bad++; $display("FAIL async_reset got=%b exp=100000000000", {ball_rst, ball_en, serve_dir, score_l, score_r, game_over}); end
    cyc(); rst = 1'b0; cyc(); cyc();
    n_cmp++; if ({ball_rst, ball_en} !== 2'b10) begin n_bad++; $display("FAIL post_reset_idle got=%b exp=10", {ball_rst, ball_en}); end
    pulse_start(); do_serve();
    n_cmp++; if (ball_en !== 1'b1) begin n_bad++; $display("FAIL start_after_reset ball_en got=%b exp=1", ball_en); end
  endtask

  task automatic test_serve_timing();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    // A tick on the entry edge must not count.
    start = 1'b1; frame_tick = 1'b1; cyc(); start = 1'b0; frame_tick = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      for (int c = 0; c < 9; c++) begin
        cyc();
        n_cmp++; if (ball_en !== 1'b0) begin n_bad++; $display("FAIL serve_wait t=%0d c=%0d ball_en got=%b exp=0", t, c, ball_en); end
      end
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      n_cmp++; if ({ball_en, ball_rst} !== ((t == 3) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL serve_tick t=%0d got=%b exp=%b", t, {ball_en, ball_rst}, (t == 3) ? 2'b10 : 2'b01); end
    end
  endtask

  task automatic test_left_miss();
    pulse_miss(1'b1, 1'b0);
    n_cmp++; if ({score_r_inc, score_l_inc, score_clr} !== 3'b100) begin n_bad++; $display("FAIL lmiss_pulse got=%b exp=100", {score_r_inc, score_l_inc, score_clr}); end
    n_cmp++; if ({score_r, score_l} !== 8'h10) begin n_bad++; $display("FAIL lmiss_scores got=%h exp=10", {score_r, score_l}); end
    n_cmp++; if ({serve_dir, ball_en, ball_rst} !== 3'b001) begin n_bad++; $display("FAIL lmiss_ball got=%b exp=001", {serve_dir, ball_en, ball_rst}); end
    cyc();
    n_cmp++; if ({score_r_inc, ball_en, game_over} !== 3'b000) begin n_bad++; $display("FAIL lmiss_after got=%b exp=000", {score_r_inc, ball_en, game_over}); end
    do_serve();
    n_cmp++; if (ball_en !== 1'b1) begin n_bad++; $display("FAIL lmiss_reserve ball_en got=%b exp=1", ball_en); end
  endtask

  task automatic test_simul_miss();
    pulse_miss(1'b1, 1'b1);
    n_cmp++; if ({score_r_inc, score_l_inc, score_r, score_l} !== {2'b10, 8'h20}) begin n_bad++; $display("FAIL simul_edge got=%b/%h exp=10/20", {score_r_inc, score_l_inc}, {score_r, score_l}); end
    cyc();
    n_cmp++; if ({score_r_inc, score_l_inc, score_r, score_l} !== {2'b00, 8'h20}) begin n_bad++; $display("FAIL simul_after got=%b/%h exp=00/20", {score_r_inc, score_l_inc}, {score_r, score_l}); end
    do_serve();
  endtask

  task automatic test_start_in_play();
    pulse_start(); cyc();
    n_cmp++; if ({ball_en, score_clr, score_r, score_l} !== {2'b10, 8'h20}) begin n_bad++; $display("FAIL play_start got=%b/%h exp=10/20", {ball_en, score_clr}, {score_r, score_l}); end
  endtask

  task automatic test_match_end();
    for (int i = 1; i <= 10; i++) begin
      pulse_miss(1'b0, 1'b1);
      n_cmp++; if ({score_l_inc, serve_dir, score_l} !== {2'b11, 4'(i)}) begin n_bad++; $display("FAIL rmiss_%0d got=%b/%0d exp=11/%0d", i, {score_l_inc, serve_dir}, score_l, i); end
      cyc();
      if (i < 10) do_serve();
    end
    n_cmp++; if ({game_over, winner, ball_en, ball_rst, score_l_inc} !== 5'b10010) begin n_bad++; $display("FAIL over_state got=%b exp=10010", {game_over, winner, ball_en, ball_rst, score_l_inc}); end
    pulse_miss(1'b1, 1'b0); pulse_miss(1'b0, 1'b1);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; do_serve();
    n_cmp++; if ({score_l, score_r, game_over, ball_en, score_l_inc, score_r_inc} !== {8'hA2, 4'b1000}) begin n_bad++; $display("FAIL over_hold got=%h/%b exp=a2/1000", {score_l, score_r}, {game_over, ball_en, score_l_inc, score_r_inc}); end
  endtask

  task automatic test_restart();
    pulse_start();
    n_cmp++; if ({score_clr, score_l_inc, score_r_inc, game_over, score_l, score_r} !== {4'b1000, 8'h00}) begin n_bad++; $display("FAIL restart_edge got=%b/%h exp=1000/00", {score_clr, score_l_inc, score_r_inc, game_over}, {score_l, score_r}); end
    cyc();
    n_cmp++; if ({score_clr, ball_en} !== 2'b00) begin n_bad++; $display("FAIL restart_after got=%b exp=00", {score_clr, ball_en}); end
    do_serve();
    n_cmp++; if (ball_en !== 1'b1) begin n_bad++; $display("FAIL restart_serve ball_en got=%b exp=1", ball_en); end
  endtask

  initial begin
    test_reset();
    test_serve_timing();
    test_left_miss();
    test_simul_miss();
    test_start_in_play();
    test_match_end();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the pong game. It takes ball-miss events from the ball/collision logic and runs the serve → play → point → game-over cycle. It produces single-cycle score-increment pulses that drive the `win_rst` inputs of the two per-player score-display blocks. It also keeps its own copy of both scores, decides the winner, and gates and reseeds the ball.

## Interface
Parameters:
- `WIN_SCORE`, default 10: points needed to win; legal range 1–15.
- `SERVE_FRAMES`, default 60: number of `frame_tick` pulses to wait in SERVE before the ball is released; legal range 1–255.

Ports:
- `clk`, input, 1: system pixel clock; every register uses its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: start/restart request; single-cycle pulse, already debounced.
- `frame_tick`, input, 1: one-cycle pulse per video frame (end of vsync).
- `miss_l`, input, 1: the ball passed the left paddle, so the right player scores; one-cycle pulse.
- `miss_r`, input, 1: the ball passed the right paddle, so the left player scores; one-cycle pulse.
- `ball_rst`, output, 1: holds the ball at the centre position.
- `ball_en`, output, 1: allows the ball to move.
- `serve_dir`, output, 1: direction of the next serve; 0 = toward the left, 1 = toward the right.
- `score_l_inc`, output, 1: one-cycle pulse to the left score display (`win_rst`).
- `score_r_inc`, output, 1: one-cycle pulse to the right score display (`win_rst`).
- `score_clr`, output, 1: one-cycle pulse that clears both score displays on restart.
- `score_l`, output, 4: left player's score.
- `score_r`, output, 4: right player's score.
- `game_over`, output, 1: a match has been won.
- `winner`, output, 1: 0 = left player won, 1 = right player won; valid only while `game_over` = 1.

## Operation
- All outputs are registered and are a Moore function of the state and score registers.
- FSM states: IDLE, SERVE, PLAY, POINT, OVER.
- **IDLE:** `ball_rst`=1, `ball_en`=0.
  - `start`=1 → SERVE.
- **SERVE:** `ball_rst`=1, `ball_en`=0.
  - An 8-bit `frame_tick` counter is cleared on entry.
  - The edge that samples the SERVE_FRAMES-th tick → PLAY.
  - `start` and misses are ignored.
- **PLAY:** `ball_rst`=0, `ball_en`=1.
  - `miss_l` → POINT; `score_r` increments and `score_r_inc` pulses.
  - `miss_r` → POINT; `score_l` increments and `score_l_inc` pulses.
  - If `miss_l` and `miss_r` are both high in the same cycle, `miss_l` has priority: the right player scores and `miss_r` is dropped.
  - `start` is ignored.
- **POINT:** lasts one cycle, with `ball_en`=0 and `ball_rst`=1.
  - `serve_dir` is set toward the player who conceded: left conceded → 0, right conceded → 1.
  - If the updated score equals WIN_SCORE → OVER, with `winner` set to the scorer. Otherwise → SERVE.
- **OVER:** `game_over`=1, `ball_en`=0, `ball_rst`=1; scores are held.
  - `start` → SERVE. On the same edge, both scores clear to 0, `game_over` goes to 0, and `score_clr` pulses for one cycle.
- Score arithmetic is 4-bit unsigned. Scores cannot pass WIN_SCORE because OVER is entered when WIN_SCORE is reached, so no wrap occurs.
- Misses and `frame_tick` are ignored in every state except the one that uses them.

## Timing
- **Reset values:**
  - state = IDLE
  - `ball_rst`=1, `ball_en`=0, `serve_dir`=0
  - `score_l_inc`=`score_r_inc`=`score_clr`=0
  - `score_l`=`score_r`=0
  - `game_over`=0, `winner`=0
- **Reset during operation:** assertion of `rst` forces all of the above immediately, without waiting for a clock edge. After release, the block waits in IDLE for `start`.
- **Miss latency:** a miss sampled at edge k in PLAY gives the following at edge k:
  - state = POINT
  - `ball_en`=0, `ball_rst`=1
  - `score_x_inc`=1
  - score register incremented

  At edge k+1: `score_x_inc`=0 and the state is SERVE or OVER. So `ball_en` is low from k onward, and each increment pulse is exactly one cycle wide.
- **Serve duration:** with SERVE entered at edge s, PLAY is entered on the edge that samples the SERVE_FRAMES-th `frame_tick` after s. A tick sampled at edge s itself does not count.
- **Start latency:**
  - IDLE → SERVE on the edge that samples `start`.
  - OVER → SERVE on that edge, with `score_clr`=1 for exactly that one cycle.
- **Display pulses:** `score_x_inc` and `score_clr` are never high in the same cycle as each other.

## Test plan
- **Reset and start:** assert `rst` mid-PLAY with `score_l`=3 → outputs return to their reset values asynchronously. After release, pulse `start` → SERVE.
- **Serve timing:** with SERVE_FRAMES=3, apply ticks every 10 cycles → `ball_en` rises on the edge sampling the 3rd tick, not before.
- **Left miss:** `miss_l` in PLAY → `score_r_inc` high for exactly 1 cycle; `score_r` goes 0→1; `serve_dir`=0; `ball_en` low from the same edge; state returns to SERVE.
- **Simultaneous misses:** `miss_l` and `miss_r` in the same cycle → only `score_r` increments, and only one pulse is issued.
- **Match end:** with WIN_SCORE=10, drive 10 `miss_r` events (each after a serve) → `score_l`=10, `game_over`=1, `winner`=0. Further misses and ticks cause no change.
- **Restart:** `start` in OVER → `score_clr` pulses for 1 cycle, both scores are 0, `game_over`=0, state is SERVE. A `start` pulse during PLAY has no effect.
